// File: rtl/ir_sensor_array.sv
// ir_sensor_array: per-channel IR obstacle sensor conditioning.
//
// Each active-low Sense_ line is brought into the clk domain by a two-flop
// synchronizer and then debounced by its own counter. A filtered obstacle flag
// changes only after the raw value has disagreed with it for DEBOUNCE
// consecutive cycles. Any shorter disagreement clears the counter and leaves
// the flag untouched.
//
// Optional feature macro: IR_SENSOR_EVENT_EN
//   defined   : registered one-cycle obstacle_rise / obstacle_fall pulses
//   undefined : obstacle_rise / obstacle_fall tied to 0, no event registers
module ir_sensor_array #(
  parameter int unsigned CH       = 4,
  parameter int unsigned DEBOUNCE = 5000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] Sense_,
  output logic [CH-1:0] obstacles_,
  output logic          obstacle_any,
  output logic [CH-1:0] obstacle_rise,
  output logic [CH-1:0] obstacle_fall
);

  // Terminal count: a disagreement seen while the counter is here commits.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE - 1);

  // Synchronizer stages; both idle high (no reflection).
  logic [CH-1:0] r_s1;
  logic [CH-1:0] r_s2;

  // Debounce state.
  logic [CNT_W-1:0] r_cnt [CH];
  logic [CNT_W-1:0] w_cnt_d [CH];
  logic [CH-1:0]    r_obs;
  logic [CH-1:0]    w_obs_d;

  // Decoded per-channel conditions.
  logic [CH-1:0] w_raw;
  logic [CH-1:0] w_diff;
  logic [CH-1:0] w_commit;

  // Two-flop synchronizer; reset loads the idle (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= Sense_;
      r_s2 <= r_s1;
    end
  end

  // Raw obstacle is the inverted synchronized line; compare against the flag.
  always_comb begin
    w_raw    = ~r_s2;
    w_diff   = w_raw ^ r_obs;
    w_commit = '0;
    for (int i = 0; i < CH; i++) begin
      w_commit[i] = w_diff[i] && (r_cnt[i] == CntLast);
    end
  end

  // Next-state for counters and flags: clear on agreement, count while
  // disagreeing, and commit the raw value at the terminal count.
  always_comb begin
    w_obs_d = r_obs;
    for (int i = 0; i < CH; i++) begin
      w_cnt_d[i] = '0;
      if (w_commit[i]) begin
        w_obs_d[i] = w_raw[i];
      end else if (w_diff[i]) begin
        w_cnt_d[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_obs <= '0;
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_obs <= w_obs_d;
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  assign obstacles_ = r_obs;
  // Built from the flag registers only, so there is no path from Sense_.
  assign obstacle_any = |r_obs;

`ifdef IR_SENSOR_EVENT_EN
  logic [CH-1:0] r_rise;
  logic [CH-1:0] r_fall;

  // Edge pulses register on the same edge the flag commits, so they are high
  // for exactly the cycle after the change; a commit is either 0->1 or 1->0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_commit & w_raw;
      r_fall <= w_commit & ~w_raw;
    end
  end

  assign obstacle_rise = r_rise;
  assign obstacle_fall = r_fall;
`else
  assign obstacle_rise = '0;
  assign obstacle_fall = '0;
`endif

endmodule

// File: doc/ir_sensor_array.md
IR_SENSOR_ARRAY -- requirements
Module: ir_sensor_array

Interface
REQ-001 Parameter CH, default 4, number of independent IR sensor channels (legal range 1..16).
REQ-002 Parameter DEBOUNCE, default 5000, consecutive stable cycles required before a filtered output changes (legal range 1..2^CNT_W-1).
REQ-003 Parameter CNT_W, default 20, width of each per-channel debounce counter.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 Sense_  input  CH  raw IR sensor lines, asynchronous, active-low (0 = reflection/obstacle).
REQ-007 obstacles_  output  CH  debounced obstacle flags, active-high, registered.
REQ-008 obstacle_any  output  1  OR-reduction of obstacles_.
REQ-009 obstacle_rise  output  CH  one-cycle pulse per channel on a debounced 0->1 transition.
REQ-010 obstacle_fall  output  CH  one-cycle pulse per channel on a debounced 1->0 transition.

Function
REQ-011 Each Sense_ bit SHALL pass through its own two-flop synchronizer (s1, s2) before any use.
REQ-012 Per-channel raw obstacle value SHALL be raw = !s2.
REQ-013 Per channel, when raw equals obstacles_[i], the counter SHALL clear to 0 on that edge.
REQ-014 When raw differs from obstacles_[i] and counter < DEBOUNCE-1, the counter SHALL increment by 1.
REQ-015 When raw differs from obstacles_[i] and counter == DEBOUNCE-1, obstacles_[i] SHALL take raw and the counter SHALL clear to 0 on the same edge.
REQ-016 Latency: a Sense_ change sampled at edge k with no further change SHALL update obstacles_ at edge k+1+DEBOUNCE.
REQ-017 DEBOUNCE=1: obstacles_ SHALL follow !Sense_ with exactly two cycles of synchronizer delay.
REQ-018 A disagreement lasting fewer than DEBOUNCE consecutive s2 cycles SHALL leave obstacles_ unchanged and return the counter to 0.
REQ-019 The counter SHALL never exceed DEBOUNCE-1 and SHALL never wrap.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be processed in the same cycle.
REQ-021 obstacle_rise[i]/obstacle_fall[i] SHALL be registered, asserted for exactly the one cycle following the edge where obstacles_[i] changes, and never both high.
REQ-022 obstacle_any SHALL be combinational from the obstacles_ registers only (no path from Sense_).

Reset
REQ-023 While rst is high at a clk edge: s1, s2 SHALL load 1 (idle, no obstacle); counters 0; obstacles_ 0; obstacle_rise 0; obstacle_fall 0.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; no rise/fall pulse SHALL be generated by reset itself.
REQ-025 After rst deasserts, an input held low SHALL produce obstacles_=1 no earlier than edge 2+DEBOUNCE after release.

Configuration
REQ-026 Macro IR_SENSOR_EVENT_EN: when defined, obstacle_rise/obstacle_fall SHALL behave per REQ-021.
REQ-027 When IR_SENSOR_EVENT_EN is undefined, obstacle_rise and obstacle_fall SHALL be tied to 0, their registers omitted; all other behaviour SHALL be identical.

Verification
REQ-028 CH=2, DEBOUNCE=4: Sense_[0] 1->0 before edge 10, held -> obstacles_[0]=1 after edge 15, obstacle_rise[0] high one cycle, obstacle_any=1, channel 1 unchanged.
REQ-029 DEBOUNCE=4: Sense_[1] low pulse of 3 cycles -> obstacles_[1] stays 0, no pulses; repeat with 4 cycles -> obstacles_[1]=1.
REQ-030 Both channels low simultaneously, held -> both obstacles_ bits set on the same edge, both rise pulses together; release both -> both fall pulses together after DEBOUNCE+2 cycles.
REQ-031 rst pulsed at cycle 2 of a 4-cycle debounce -> counter 0, obstacles_=0, no pulse; held input then needs full 2+DEBOUNCE cycles after release.
REQ-032 DEBOUNCE=1 -> obstacles_ equals !Sense_ delayed 2 cycles for random stimulus; build without IR_SENSOR_EVENT_EN -> obstacle_rise/fall constantly 0.
